// File: rtl/cv32e40p_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types and constants for the instruction packer.
//   packer_state_e : packer FSM states
//   PK_CNOP        : encoding of c.nop, used as padding for a flushed residue
//   is_compressed  : 16-bit (RVC) instruction test on the low two bits
// ---------------------------------------------------------------------------
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    PK_IDLE,    // no stream open, instructions not accepted
    PK_EMPTY,   // next halfword lands in bits [15:0] of a fresh word
    PK_HOLD16,  // residue holds bits [15:0] of the word being built
    PK_SKIP16   // stream started at addr[1]=1, low halfword left unwritten
  } packer_state_e;

  localparam logic [15:0] PK_CNOP = 16'h0001;

  function automatic logic is_compressed(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/cv32e40p_instr_packer.sv
// ---------------------------------------------------------------------------
// cv32e40p_instr_packer
// Packs a stream of 16-bit (RVC) and 32-bit instructions into word-aligned
// 32-bit writes with byte enables.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clear_i             synchronous discard of all state
//   start_i/start_addr_i open a stream at a halfword-aligned address
//   instr_valid_i/instr_ready_o/instr_i   instruction input handshake
//   flush_i/flush_ack_o emit any held residue halfword
//   word_valid_o/word_ready_i/word_o/word_addr_o/word_be_o  output word port
//
// Configuration macro
//   CV32E40P_PACKER_CNOP_PAD_EN : when defined a flushed residue is padded
//   with c.nop and written as a full word; otherwise only the low halfword
//   is written (be 4'h3).
// ---------------------------------------------------------------------------
module cv32e40p_instr_packer
  import cv32e40p_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [31:0]           instr_i,
  input  logic                  flush_i,
  output logic                  flush_ack_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [31:0]           word_o,
  output logic [ADDR_WIDTH-1:0] word_addr_o,
  output logic [3:0]            word_be_o
);

`ifdef CV32E40P_PACKER_CNOP_PAD_EN
  localparam logic [15:0] FLUSH_PAD = PK_CNOP;
  localparam logic [3:0]  FLUSH_BE  = 4'hF;
`else
  localparam logic [15:0] FLUSH_PAD = 16'h0000;
  localparam logic [3:0]  FLUSH_BE  = 4'h3;
`endif

  packer_state_e         state;
  packer_state_e         state_next;
  logic [15:0]           residue;
  logic [15:0]           residue_next;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic                  out_free;
  logic                  instr_fire;
  logic                  emit;
  logic [31:0]           emit_data;
  logic [3:0]            emit_be;

  // Start address bit 0 is meaningless for halfword-aligned streams.
  logic                  unused_addr_bit;
  assign unused_addr_bit = start_addr_i[0];

  // The output register can take a new word when empty or draining now.
  assign out_free      = !word_valid_o || word_ready_i;
  assign instr_ready_o = out_free && !clear_i && !start_i && !flush_i && (state != PK_IDLE);
  assign flush_ack_o   = flush_i && out_free && !clear_i && !start_i;
  assign instr_fire    = instr_valid_i && instr_ready_o;

  always_comb begin
    state_next   = state;
    residue_next = residue;
    emit         = 1'b0;
    emit_data    = 32'h0;
    emit_be      = 4'h0;
    if (start_i) begin
      state_next   = start_addr_i[1] ? PK_SKIP16 : PK_EMPTY;
      residue_next = 16'h0;
    end else if (flush_ack_o) begin
      // Only HOLD16 has something to write; other states just ack.
      if (state == PK_HOLD16) begin
        emit         = 1'b1;
        emit_data    = {FLUSH_PAD, residue};
        emit_be      = FLUSH_BE;
        state_next   = PK_EMPTY;
        residue_next = 16'h0;
      end
    end else if (instr_fire) begin
      case (state)
        PK_EMPTY: begin
          if (is_compressed(instr_i)) begin
            residue_next = instr_i[15:0];
            state_next   = PK_HOLD16;
          end else begin
            emit      = 1'b1;
            emit_data = instr_i;
            emit_be   = 4'hF;
          end
        end
        PK_HOLD16: begin
          emit      = 1'b1;
          emit_data = {instr_i[15:0], residue};
          emit_be   = 4'hF;
          if (is_compressed(instr_i)) begin
            state_next = PK_EMPTY;
          end else begin
            // Upper half of a 32-bit instruction straddles into the next word.
            residue_next = instr_i[31:16];
          end
        end
        PK_SKIP16: begin
          emit      = 1'b1;
          emit_data = {instr_i[15:0], 16'h0};
          emit_be   = 4'hC;
          if (is_compressed(instr_i)) begin
            state_next = PK_EMPTY;
          end else begin
            residue_next = instr_i[31:16];
            state_next   = PK_HOLD16;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PK_IDLE;
      residue      <= 16'h0;
      next_addr    <= '0;
      word_valid_o <= 1'b0;
      word_o       <= 32'h0;
      word_addr_o  <= '0;
      word_be_o    <= 4'h0;
    end else if (clear_i) begin
      // Drops any pending word without completing its handshake.
      state        <= PK_IDLE;
      residue      <= 16'h0;
      next_addr    <= '0;
      word_valid_o <= 1'b0;
      word_o       <= 32'h0;
      word_addr_o  <= '0;
      word_be_o    <= 4'h0;
    end else begin
      state   <= state_next;
      residue <= residue_next;
      if (start_i) begin
        next_addr <= {start_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (emit) begin
        next_addr <= next_addr + ADDR_WIDTH'(4);
      end
      if (emit) begin
        word_valid_o <= 1'b1;
        word_o       <= emit_data;
        word_addr_o  <= next_addr;
        word_be_o    <= emit_be;
      end else if (word_ready_i) begin
        word_valid_o <= 1'b0;
      end
    end
  end

endmodule
